// File: rtl/mcp4725_sched_if.sv
// Request/engine signal bundle for mcp4725_sched.
// The slave modport is the scheduler; master is the requesters plus IIC engine side.
interface mcp4725_sched_if;
    logic        iDacReq;
    logic [11:0] iDacCode;
    logic        oDacAck;
    logic        iRdReq;
    logic [7:0]  iRdAddr;
    logic        oRdAck;
    logic [7:0]  oRdData;
    logic        oErr;
    logic        oBusy;
    logic [1:0]  oCall;
    logic [7:0]  oAddr;
    logic [7:0]  oData;
    logic        iDone;
    logic [7:0]  iData;
    logic        oEngRstN;

    modport slave (
        input  iDacReq, iDacCode, iRdReq, iRdAddr, iDone, iData,
        output oDacAck, oRdAck, oRdData, oErr, oBusy, oCall, oAddr, oData, oEngRstN
    );

    modport master (
        output iDacReq, iDacCode, iRdReq, iRdAddr, iDone, iData,
        input  oDacAck, oRdAck, oRdData, oErr, oBusy, oCall, oAddr, oData, oEngRstN
    );
endinterface

// File: rtl/mcp4725_sched.sv
// Round-robin DAC-write / EEPROM-read scheduler in front of the shared IIC engine.
// Define MCP4725_SCHED_WDOG_EN to add the RUN timeout watchdog and engine reset pulse.
module mcp4725_sched #(
`ifdef MCP4725_SCHED_WDOG_EN
    parameter logic [19:0] TIMEOUT  = 20'd200000,
`endif
    parameter logic [7:0]  IDLE_GAP = 8'd8
) (
    input logic            CLOCK,
    input logic            RESET,
    mcp4725_sched_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StGrant, StRun, StDone, StErr, StGap} stateT;

    stateT       stateQ, stateD;
    logic        lastDacQ, lastDacD;
    logic        selDacQ, selDacD;
    logic [7:0]  addrQ, addrD;
    logic [7:0]  dataQ, dataD;
    logic [7:0]  rdDataQ, rdDataD;
    logic [7:0]  gapCntQ, gapCntD;
`ifdef MCP4725_SCHED_WDOG_EN
    logic [19:0] wdCntQ, wdCntD;
    logic        errCntQ, errCntD;
`endif

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            stateQ   <= StIdle;
            lastDacQ <= 1'b0;
            selDacQ  <= 1'b0;
            addrQ    <= 8'h00;
            dataQ    <= 8'h00;
            rdDataQ  <= 8'h00;
            gapCntQ  <= 8'h00;
`ifdef MCP4725_SCHED_WDOG_EN
            wdCntQ   <= 20'd0;
            errCntQ  <= 1'b0;
`endif
        end else begin
            stateQ   <= stateD;
            lastDacQ <= lastDacD;
            selDacQ  <= selDacD;
            addrQ    <= addrD;
            dataQ    <= dataD;
            rdDataQ  <= rdDataD;
            gapCntQ  <= gapCntD;
`ifdef MCP4725_SCHED_WDOG_EN
            wdCntQ   <= wdCntD;
            errCntQ  <= errCntD;
`endif
        end
    end

    always_comb begin
        stateD   = stateQ;
        lastDacD = lastDacQ;
        selDacD  = selDacQ;
        addrD    = addrQ;
        dataD    = dataQ;
        rdDataD  = rdDataQ;
        gapCntD  = gapCntQ;
`ifdef MCP4725_SCHED_WDOG_EN
        wdCntD   = wdCntQ;
        errCntD  = errCntQ;
`endif
        unique case (stateQ)
            StIdle: begin
                if (bus.iDacReq || bus.iRdReq) begin
                    stateD  = StGrant;
                    // On a tie the requester not served last wins
                    selDacD = bus.iDacReq && (!bus.iRdReq || !lastDacQ);
                end
            end
            StGrant: begin
                stateD   = StRun;
                lastDacD = selDacQ;
                if (selDacQ) begin
                    addrD = bus.iDacCode[11:4];
                    dataD = {bus.iDacCode[3:0], 4'b0000};
                end else begin
                    addrD = bus.iRdAddr;
                    dataD = 8'h00;
                end
`ifdef MCP4725_SCHED_WDOG_EN
                wdCntD = 20'd0;
`endif
            end
            StRun: begin
                if (bus.iDone) begin
                    stateD = StDone;
                    if (!selDacQ) rdDataD = bus.iData;
`ifdef MCP4725_SCHED_WDOG_EN
                end else if (wdCntQ == TIMEOUT - 20'd1) begin
                    stateD  = StErr;
                    errCntD = 1'b0;
                end else begin
                    wdCntD = wdCntQ + 20'd1;
`endif
                end
            end
            StDone: begin
                stateD  = StGap;
                gapCntD = 8'h00;
            end
`ifdef MCP4725_SCHED_WDOG_EN
            StErr: begin
                if (errCntQ) begin
                    stateD  = StGap;
                    gapCntD = 8'h00;
                end else begin
                    errCntD = 1'b1;
                end
            end
`endif
            StGap: begin
                if (gapCntQ == IDLE_GAP - 8'd1) stateD = StIdle;
                else gapCntD = gapCntQ + 8'd1;
            end
            default: stateD = StIdle;
        endcase
    end

    logic ackNow;
`ifdef MCP4725_SCHED_WDOG_EN
    assign ackNow       = (stateQ == StDone) || (stateQ == StErr && !errCntQ);
    assign bus.oErr     = (stateQ == StErr) && !errCntQ;
    assign bus.oEngRstN = (stateQ != StErr);
`else
    assign ackNow       = (stateQ == StDone);
    assign bus.oErr     = 1'b0;
    assign bus.oEngRstN = 1'b1;
`endif

    // Call is decoded straight from the state so it drops the cycle after done
    assign bus.oCall   = (stateQ == StRun) ? {selDacQ, !selDacQ} : 2'b00;
    assign bus.oDacAck = ackNow && selDacQ;
    assign bus.oRdAck  = ackNow && !selDacQ;
    assign bus.oBusy   = (stateQ != StIdle);
    assign bus.oAddr   = addrQ;
    assign bus.oData   = dataQ;
    assign bus.oRdData = rdDataQ;

endmodule

// File: tb/tb_mcp4725_sched.sv
// Randomized self-checking bench for mcp4725_sched against a transaction-level model.
// Covers both builds; the watchdog section follows MCP4725_SCHED_WDOG_EN.
module tb_mcp4725_sched;

    localparam int TbGap = 8;
`ifdef MCP4725_SCHED_WDOG_EN
    localparam int DirLat = 900;
`else
    localparam int DirLat = 5700;
`endif

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    mcp4725_sched_if bus ();

`ifdef MCP4725_SCHED_WDOG_EN
    mcp4725_sched #(.TIMEOUT(20'd1000), .IDLE_GAP(8'(TbGap))) dut (
        .CLOCK(CLOCK), .RESET(RESET), .bus(bus));
`else
    mcp4725_sched #(.IDLE_GAP(8'(TbGap))) dut (
        .CLOCK(CLOCK), .RESET(RESET), .bus(bus));
`endif

    always #5 CLOCK = ~CLOCK;

    int nVec = 0;
    int nErr = 0;

    // Model state
    bit         dacPend, rdPend, lastDac, holdBoth;
    logic [11:0] dacCode;
    logic [7:0]  rdAddr, rdModel;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive();
        bus.iDacReq  = dacPend;
        bus.iDacCode = dacCode;
        bus.iRdReq   = rdPend;
        bus.iRdAddr  = rdAddr;
    endtask

    task automatic checkResetVals(input string tag);
        checkVal({tag, "_call"}, bus.oCall, 2'b00);
        checkVal({tag, "_addr"}, bus.oAddr, 8'h00);
        checkVal({tag, "_data"}, bus.oData, 8'h00);
        checkVal({tag, "_rdd"}, bus.oRdData, 8'h00);
        checkVal({tag, "_acks"}, {bus.oDacAck, bus.oRdAck, bus.oErr, bus.oBusy}, 4'b0000);
        checkVal({tag, "_engrst"}, bus.oEngRstN, 1'b1);
    endtask

    // Entered in an IDLE cycle with requests driven; leaves in the next IDLE cycle.
    task automatic doTxn(input int lat, input logic [7:0] engByte);
        bit         winDac;
        logic [1:0] expCall;
        logic [7:0] expAddr, expData;
        winDac  = dacPend && (!rdPend || !lastDac);
        expCall = winDac ? 2'b10 : 2'b01;
        expAddr = winDac ? dacCode[11:4] : rdAddr;
        expData = winDac ? {dacCode[3:0], 4'h0} : 8'h00;
        step();
        bus.iDone = 1'b0;
        checkVal("grant_busy", bus.oBusy, 1'b1);
        checkVal("grant_call", bus.oCall, 2'b00);
        step();
        checkVal("run_call", bus.oCall, expCall);
        checkVal("run_addr", bus.oAddr, expAddr);
        checkVal("run_data", bus.oData, expData);
        lastDac = winDac;
        // Dropping the request mid-run must not abort
        if (!holdBoth && $urandom_range(0, 3) == 0) begin
            if (winDac) bus.iDacReq = 1'b0;
            else bus.iRdReq = 1'b0;
        end
        repeat (lat - 1) step();
        checkVal("run_hold_call", bus.oCall, expCall);
        checkVal("run_no_ack", {bus.oDacAck, bus.oRdAck}, 2'b00);
        bus.iDone = 1'b1;
        bus.iData = engByte;
        step();
        bus.iDone = 1'b0;
        bus.iData = 8'($urandom);
        if (!winDac) rdModel = engByte;
        checkVal("ack", {bus.oDacAck, bus.oRdAck}, {winDac, !winDac});
        checkVal("ack_err", bus.oErr, 1'b0);
        checkVal("ack_call_off", bus.oCall, 2'b00);
        checkVal("ack_rdd", bus.oRdData, rdModel);
        if (!holdBoth) begin
            if (winDac) dacPend = 1'b0;
            else rdPend = 1'b0;
        end
        drive();
        for (int g = 0; g < TbGap; g++) begin
            step();
            checkVal("gap_noack", {bus.oDacAck, bus.oRdAck, bus.oBusy}, 3'b001);
            checkVal("gap_rdd", bus.oRdData, rdModel);
            bus.iDone = 1'($urandom);
            bus.iData = 8'($urandom);
        end
        step();
        bus.iDone = 1'b0;
        checkVal("idle_busy", bus.oBusy, 1'b0);
        checkVal("idle_rdd", bus.oRdData, rdModel);
    endtask

    initial begin
        dacPend = 0; rdPend = 0; lastDac = 0; holdBoth = 0;
        dacCode = '0; rdAddr = '0; rdModel = '0;
        drive();
        bus.iDone = 1'b0;
        bus.iData = 8'h00;
        RESET = 1'b0;
        repeat (3) step();
        checkResetVals("rst");
        RESET = 1'b1;

        // Directed DAC write and EEPROM read
        dacPend = 1; dacCode = 12'hABC; drive();
        doTxn(DirLat, 8'h77);
        rdPend = 1; rdAddr = 8'h12; drive();
        doTxn(30, 8'h5A);
        checkVal("rd_hold_5a", bus.oRdData, 8'h5A);

        // Both requests held continuously: order must alternate
        holdBoth = 1; dacPend = 1; rdPend = 1; drive();
        for (int k = 0; k < 4; k++) begin
            bus.iDone = 1'b1;  // ignored in IDLE
            doTxn(int'($urandom_range(1, 20)), 8'($urandom));
        end
        holdBoth = 0;

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            if (!dacPend && $urandom_range(0, 1) == 1) begin
                dacPend = 1; dacCode = 12'($urandom);
            end
            if (!rdPend && $urandom_range(0, 1) == 1) begin
                rdPend = 1; rdAddr = 8'($urandom);
            end
            if (!dacPend && !rdPend) begin
                rdPend = 1; rdAddr = 8'($urandom);
            end
            drive();
            if ($urandom_range(0, 2) == 0) bus.iDone = 1'b1;
            doTxn(int'($urandom_range(1, 40)), 8'($urandom));
        end

        // Reset mid-RUN, then a normal transaction
        rdPend = 0; dacPend = 1; dacCode = 12'($urandom); drive();
        step();
        step();
        checkVal("pre_rst_call", bus.oCall, 2'b10);
        #2 RESET = 1'b0;
        #1;
        dacPend = 0; rdPend = 0; drive();
        lastDac = 0; rdModel = 8'h00;
        checkResetVals("midrst");
        step();
        checkResetVals("midrst_hold");
        RESET = 1'b1;
        dacPend = 1; rdPend = 1; dacCode = 12'($urandom); rdAddr = 8'($urandom); drive();
        doTxn(12, 8'($urandom));
        doTxn(12, 8'h3C);

        // Engine never answers
        dacPend = 1; dacCode = 12'h5A5; drive();
        step();
        step();
        checkVal("wd_run_call", bus.oCall, 2'b10);
`ifdef MCP4725_SCHED_WDOG_EN
        repeat (999) step();
        checkVal("wd_last_run", bus.oCall, 2'b10);
        checkVal("wd_last_noack", bus.oDacAck, 1'b0);
        step();
        checkVal("wd_err1", {bus.oDacAck, bus.oRdAck, bus.oErr, bus.oEngRstN}, 4'b1010);
        checkVal("wd_err1_call", bus.oCall, 2'b00);
        dacPend = 0; drive();
        step();
        checkVal("wd_err2", {bus.oDacAck, bus.oErr, bus.oEngRstN, bus.oBusy}, 4'b0001);
        step();
        checkVal("wd_gap", {bus.oEngRstN, bus.oBusy}, 2'b11);
        repeat (TbGap) step();
        checkVal("wd_idle", bus.oBusy, 1'b0);
`else
        repeat (2000) step();
        checkVal("nowd_busy", bus.oBusy, 1'b1);
        checkVal("nowd_call", bus.oCall, 2'b10);
        checkVal("nowd_flags", {bus.oDacAck, bus.oErr, bus.oEngRstN}, 3'b001);
        RESET = 1'b0;
        dacPend = 0; drive();
        #1;
        checkResetVals("nowd_rst");
        step();
        RESET = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
